pkt_capture_buffer: RTL and testbench
=====================================

// Module: pkt_capture_buffer
// PURPOSE
//  Parametrised receive-packet capture buffer between an RMII/MII byte receiver and the JTAG debug port.
//  Stores {eop,data} entries in block RAM. Supports stop-when-full or ring (overwrite-oldest) mode.
//  Provides a pop-on-read data register, status and packet counters, software enable/clear.
//  Replaces the fixed 4096-entry, write-once logger.
// PARAMETERS
//  ADDR_BITS   12           log2 of buffer depth; DEPTH = 2**ADDR_BITS entries
//  DATA_BITS   8            receive byte width; entry width = DATA_BITS+1 (eop flag in MSB)
//  RING        0            0: drop new entries when full; 1: overwrite oldest entry when full
//  ID_VALUE    32'h50434231 value returned by register 0
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  reset         in   1          synchronous, active-high reset
//  i_rxdata      in   DATA_BITS  received byte
//  i_rxvalid     in   1          i_rxdata valid this cycle
//  i_rxeop       in   1          end of packet; may coincide with i_rxvalid or stand alone
//  i_dbg_addr    in   3          debug register address
//  i_dbg_rd      in   1          one-cycle read strobe
//  i_dbg_wr      in   1          one-cycle write strobe
//  i_dbg_wdata   in   32         debug write data
//  o_dbg_rdata   out  32         debug read data, registered
//  o_overflow    out  1          sticky: an entry was dropped (RING=0) or overwritten (RING=1)
// BEHAVIOUR
//  Reset: wrptr=rdptr=0, count=0, pkt_count=0, drop_count=0, o_overflow=0, o_dbg_rdata=0, enable=1.
//  Capture event: enable & (i_rxvalid | i_rxeop).
//    Each capture event writes entry {i_rxeop, i_rxdata} at wrptr in the same cycle.
//  Pointers wrap modulo DEPTH. count is ADDR_BITS+1 bits, range 0..DEPTH.
//  Full (count==DEPTH), RING=0: capture dropped; drop_count++ (saturates at 16'hFFFF); o_overflow<=1.
//  Full, RING=1: entry written; wrptr++, rdptr++, count unchanged; o_overflow<=1.
//  pkt_count (16b, wraps) increments on each written entry with eop=1. Dropped eop entries do not count.
//  Reads: o_dbg_rdata is valid the cycle after i_dbg_rd; holds its value otherwise.
//    addr0: ID_VALUE
//    addr1: pop {empty, 22'd0, entry} zero-extended to 32 bits, empty in bit31.
//           If count>0: return entry at rdptr, empty=0, rdptr++, count--.
//           If count==0: return 32'h80000000; no pointer change.
//    addr2: {o_overflow, enable, count zero-extended to 14b, wrptr zero-extended to 16b}
//    addr3: {drop_count, pkt_count}
//    addr4: control readback {30'd0, 1'b0, enable}
//    addr5: timestamp (see CONFIGURATION)
//    addr6-7: 0
//  Writes: only addr4 is writable.
//    bit0 -> enable.
//    bit1 -> clear (self-clearing pulse): zeroes pointers, count, pkt_count, drop_count and o_overflow.
//    Buffer RAM contents are not cleared.
//  Simultaneous capture and pop:
//    not full: count unchanged, both pointers advance.
//    full, RING=0: pop frees a slot first, so the capture is accepted (no drop).
//    RING=1: pop advances rdptr once only.
//  Simultaneous clear and capture/pop: clear wins; capture discarded; pop returns the pre-clear entry.
//  Reset mid-packet: remaining bytes of that packet are captured as ordinary entries (no resync).
//  No combinational path from inputs to outputs.
// CONFIGURATION
//  Macro PKTCAP_TIMESTAMP_EN.
//  Defined: free-running 32b cycle counter, 0 at reset, wraps.
//    On each accepted eop write, latch counter into last_eop_ts; addr5 returns last_eop_ts.
//    Clear zeroes last_eop_ts but not the counter.
//  Undefined: no counter or latch logic; addr5 reads 0.
// TESTING
//  T1: reset; read addr0 -> 32'h50434231; read addr2 -> 32'h40000000; read addr1 -> 32'h80000000.
//  T2: capture bytes 0x11,0x22,0x33 with eop on 0x33, then pop x4.
//      Pops return 0x011, 0x022, 0x133, 32'h80000000. addr3 -> 32'h00000001.
//  T3: RING=0, ADDR_BITS=4: 20 captures.
//      count=16, drop_count=4, o_overflow=1; first pop returns entry 0.
//  T4: RING=1, ADDR_BITS=4: 20 captures.
//      count=16, o_overflow=1; first pop returns entry 4; drop_count=0.
//  T5: full buffer with pop and capture in the same cycle -> no drop; count stays 16.
//      Write addr4=32'h3 -> count, pkt_count, overflow all 0; enable=1.
//  T6: PKTCAP_TIMESTAMP_EN: eop accepted at cycle N after reset -> addr5 == N.
//      Macro undefined: addr5 == 0.

Source files
------------

// File: rtl/pkt_capture_buffer.sv
// pkt_capture_buffer: receive-byte capture buffer read through a debug register file with a pop port.
// Optional feature macro PKTCAP_TIMESTAMP_EN adds a cycle timestamp of the last accepted eop entry.
module pkt_capture_buffer #(
    parameter int          ADDR_BITS = 12,
    parameter int          DATA_BITS = 8,
    parameter int          RING      = 0,
    parameter logic [31:0] ID_VALUE  = 32'h50434231
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] i_rxdata,
    input  logic                 i_rxvalid,
    input  logic                 i_rxeop,
    input  logic [2:0]           i_dbg_addr,
    input  logic                 i_dbg_rd,
    input  logic                 i_dbg_wr,
    input  logic [31:0]          i_dbg_wdata,
    output logic [31:0]          o_dbg_rdata,
    output logic                 o_overflow
);
    localparam int ENTRY_BITS = DATA_BITS + 1;
    localparam int DEPTH      = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wrptr;
    logic [ADDR_BITS-1:0]  rdptr;
    logic [ADDR_BITS:0]    count;
    logic [15:0]           pkt_count;
    logic [15:0]           drop_count;
    logic                  enable;
    logic [31:0]           timestamp;

    logic                  ctrl_wr;
    logic                  clear;
    logic                  capture;
    logic                  full;
    logic                  pop;
    logic                  accept;
    logic                  overwrite;
    logic                  drop;
    logic [ENTRY_BITS-1:0] head;
    logic [31:0]           rd_value;
    logic                  wdata_unused;

    assign wdata_unused = ^i_dbg_wdata[31:2];

    always_comb begin
        ctrl_wr   = i_dbg_wr && (i_dbg_addr == 3'd4);
        clear     = ctrl_wr && i_dbg_wdata[1];
        capture   = enable && (i_rxvalid || i_rxeop) && !clear;
        full      = (count == FULL_COUNT);
        pop       = i_dbg_rd && (i_dbg_addr == 3'd1) && (count != '0);
        // a same-cycle pop frees a slot first, so a full buffer then neither drops nor overwrites
        accept    = capture && (!full || pop || (RING != 0));
        overwrite = capture && full && !pop && (RING != 0);
        drop      = capture && full && !pop && (RING == 0);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wrptr] <= {i_rxeop, i_rxdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wrptr      <= '0;
            rdptr      <= '0;
            count      <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (accept) begin
                wrptr <= wrptr + 1'b1;
            end
            if (pop || overwrite) begin
                rdptr <= rdptr + 1'b1;
            end
            if (accept && !pop && !overwrite) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end
            if (accept && i_rxeop) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (drop || overwrite) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable <= 1'b1;
        end else if (ctrl_wr) begin
            enable <= i_dbg_wdata[0];
        end
    end

`ifdef PKTCAP_TIMESTAMP_EN
    logic [31:0] cycle_count;

    // the counter keeps running across a software clear; only the latched stamp is zeroed
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            timestamp   <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (clear) begin
                timestamp <= '0;
            end else if (accept && i_rxeop) begin
                timestamp <= cycle_count;
            end
        end
    end
`else
    assign timestamp = '0;
`endif

    assign head = mem[rdptr];

    always_comb begin
        rd_value = '0;
        case (i_dbg_addr)
            3'd0:    rd_value = ID_VALUE;
            3'd1:    rd_value = (count != '0) ? {1'b0, 31'(head)} : 32'h8000_0000;
            3'd2:    rd_value = {o_overflow, enable, 14'(count), 16'(wrptr)};
            3'd3:    rd_value = {drop_count, pkt_count};
            3'd4:    rd_value = {31'd0, enable};
            3'd5:    rd_value = timestamp;
            default: rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_dbg_rdata <= '0;
        end else if (i_dbg_rd) begin
            o_dbg_rdata <= rd_value;
        end
    end
endmodule

// File: tb/tb_pkt_capture_buffer.sv
// Bench for pkt_capture_buffer: drop-mode and ring-mode instances (16 entries) share one stimulus stream
// and are scored against a queue-based reference model, plus directed register checks.
module tb_pkt_capture_buffer;
    localparam int DEPTH = 16;
    localparam logic [31:0] ID = 32'h50434231;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rxdata = '0;
    logic        rxvalid = 1'b0;
    logic        rxeop = 1'b0;
    logic [2:0]  dbg_addr = '0;
    logic        dbg_rd = 1'b0;
    logic        dbg_wr = 1'b0;
    logic [31:0] dbg_wdata = '0;
    logic [31:0] dut_rdata [2];
    logic        dut_ovf [2];

    always #5 clk = ~clk;

    pkt_capture_buffer #(.ADDR_BITS(4), .DATA_BITS(8), .RING(0), .ID_VALUE(ID)) u_drop (
        .clk(clk), .reset(reset), .i_rxdata(rxdata), .i_rxvalid(rxvalid), .i_rxeop(rxeop),
        .i_dbg_addr(dbg_addr), .i_dbg_rd(dbg_rd), .i_dbg_wr(dbg_wr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_rdata(dut_rdata[0]), .o_overflow(dut_ovf[0]));

    pkt_capture_buffer #(.ADDR_BITS(4), .DATA_BITS(8), .RING(1), .ID_VALUE(ID)) u_ring (
        .clk(clk), .reset(reset), .i_rxdata(rxdata), .i_rxvalid(rxvalid), .i_rxeop(rxeop),
        .i_dbg_addr(dbg_addr), .i_dbg_rd(dbg_rd), .i_dbg_wr(dbg_wr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_rdata(dut_rdata[1]), .o_overflow(dut_ovf[1]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference model: index 0 = drop mode, index 1 = ring mode
    logic [8:0]  mq [2][$];
    int          m_wr [2];
    logic [15:0] m_pkt [2];
    logic [15:0] m_drop [2];
    logic        m_ovf [2];
    logic        m_en [2];
    logic [31:0] m_rd [2];
    logic [31:0] m_ts [2];
    logic [31:0] m_cyc = '0;

    task automatic model_step(input int m);
        logic cap, clr, pop;
        logic [8:0] e;
        if (reset) begin
            mq[m].delete();
            m_wr[m] = 0; m_pkt[m] = '0; m_drop[m] = '0; m_ovf[m] = 1'b0;
            m_en[m] = 1'b1; m_rd[m] = '0; m_ts[m] = '0;
            return;
        end
        cap = m_en[m] && (rxvalid || rxeop);
        clr = dbg_wr && (dbg_addr == 3'd4) && dbg_wdata[1];
        pop = dbg_rd && (dbg_addr == 3'd1) && (mq[m].size() > 0);
        e = {rxeop, rxdata};
        if (dbg_rd) begin
            case (dbg_addr)
                3'd0: m_rd[m] = ID;
                3'd1: m_rd[m] = (mq[m].size() > 0) ? {23'd0, mq[m][0]} : 32'h8000_0000;
                3'd2: m_rd[m] = {m_ovf[m], m_en[m], 14'(mq[m].size()), 16'(m_wr[m] % DEPTH)};
                3'd3: m_rd[m] = {m_drop[m], m_pkt[m]};
                3'd4: m_rd[m] = {31'd0, m_en[m]};
`ifdef PKTCAP_TIMESTAMP_EN
                3'd5: m_rd[m] = m_ts[m];
`endif
                default: m_rd[m] = '0;
            endcase
        end
        if (clr) begin
            mq[m].delete();
            m_wr[m] = 0; m_pkt[m] = '0; m_drop[m] = '0; m_ovf[m] = 1'b0; m_ts[m] = '0;
        end else begin
            if (pop) void'(mq[m].pop_front());
            if (cap) begin
                if (mq[m].size() < DEPTH || m == 1) begin
                    if (mq[m].size() == DEPTH) begin
                        void'(mq[m].pop_front());
                        m_ovf[m] = 1'b1;
                    end
                    mq[m].push_back(e);
                    m_wr[m] = m_wr[m] + 1;
                    if (rxeop) begin
                        m_pkt[m] = m_pkt[m] + 16'd1;
                        m_ts[m] = m_cyc;
                    end
                end else begin
                    if (m_drop[m] != 16'hFFFF) m_drop[m] = m_drop[m] + 16'd1;
                    m_ovf[m] = 1'b1;
                end
            end
        end
        if (dbg_wr && dbg_addr == 3'd4) m_en[m] = dbg_wdata[0];
    endtask

    task automatic step(input logic [7:0] d, input logic v, input logic e, input logic [2:0] a,
                        input logic r, input logic w, input logic [31:0] wd);
        rxdata = d; rxvalid = v; rxeop = e; dbg_addr = a; dbg_rd = r; dbg_wr = w; dbg_wdata = wd;
        @(posedge clk);
        model_step(0);
        model_step(1);
        m_cyc = reset ? 32'd0 : m_cyc + 32'd1;
        @(negedge clk);
        if (r && !reset) begin
            check_val("sb_rdata_drop", dut_rdata[0], m_rd[0]);
            check_val("sb_rdata_ring", dut_rdata[1], m_rd[1]);
        end
        check_val("sb_ovf_drop", {31'd0, dut_ovf[0]}, {31'd0, m_ovf[0]});
        check_val("sb_ovf_ring", {31'd0, dut_ovf[1]}, {31'd0, m_ovf[1]});
        rxvalid = 1'b0; rxeop = 1'b0; dbg_rd = 1'b0; dbg_wr = 1'b0;
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic cap(input logic [7:0] d, input logic e);
        step(d, 1'b1, e, 3'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] v0, output logic [31:0] v1);
        step(8'h00, 1'b0, 1'b0, a, 1'b1, 1'b0, 32'd0);
        v0 = dut_rdata[0];
        v1 = dut_rdata[1];
    endtask

    task automatic wr_ctrl(input logic [31:0] wd);
        step(8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, wd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
    endtask

    logic [31:0] v0, v1;

    initial begin
        @(negedge clk);
        do_reset();

        // reset state
        check_val("t1_rdata_reset", dut_rdata[0], 32'd0);
        check_val("t1_ovf_reset", {31'd0, dut_ovf[1]}, 32'd0);
        rd_reg(3'd0, v0, v1); check_val("t1_id_drop", v0, ID); check_val("t1_id_ring", v1, ID);
        rd_reg(3'd2, v0, v1); check_val("t1_stat_drop", v0, 32'h4000_0000); check_val("t1_stat_ring", v1, 32'h4000_0000);
        rd_reg(3'd1, v0, v1); check_val("t1_empty_drop", v0, 32'h8000_0000); check_val("t1_empty_ring", v1, 32'h8000_0000);
        rd_reg(3'd4, v0, v1); check_val("t1_ctrl", v0, 32'h1);

        // three bytes, eop on the last
        cap(8'h11, 1'b0); cap(8'h22, 1'b0); cap(8'h33, 1'b1);
        rd_reg(3'd1, v0, v1); check_val("t2_pop0", v0, 32'h011); check_val("t2_pop0_ring", v1, 32'h011);
        rd_reg(3'd1, v0, v1); check_val("t2_pop1", v0, 32'h022);
        rd_reg(3'd1, v0, v1); check_val("t2_pop2", v0, 32'h133); check_val("t2_pop2_ring", v1, 32'h133);
        rd_reg(3'd1, v0, v1); check_val("t2_pop3", v0, 32'h8000_0000);
        rd_reg(3'd3, v0, v1); check_val("t2_cnt", v0, 32'h1); check_val("t2_cnt_ring", v1, 32'h1);

        // overfill by four entries
        wr_ctrl(32'h3);
        for (int i = 0; i < 20; i++) cap(8'(i), 1'b0);
        check_val("t3_ovf_pin", {31'd0, dut_ovf[0]}, 32'h1);
        check_val("t4_ovf_pin", {31'd0, dut_ovf[1]}, 32'h1);
        rd_reg(3'd2, v0, v1); check_val("t3_stat", v0, 32'hC010_0000); check_val("t4_stat", v1, 32'hC010_0004);
        rd_reg(3'd3, v0, v1); check_val("t3_drops", v0, 32'h0004_0000); check_val("t4_drops", v1, 32'h0);
        rd_reg(3'd1, v0, v1); check_val("t3_first", v0, 32'h000); check_val("t4_first", v1, 32'h004);

        // refill, then pop and capture together while full
        cap(8'hAA, 1'b0);
        step(8'hBB, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'd0);
        check_val("t5_pop_drop", dut_rdata[0], 32'h001); check_val("t5_pop_ring", dut_rdata[1], 32'h005);
        rd_reg(3'd2, v0, v1); check_val("t5_stat_drop", v0, 32'hC010_0002); check_val("t5_stat_ring", v1, 32'hC010_0006);
        rd_reg(3'd3, v0, v1); check_val("t5_drops", v0, 32'h0004_0000);
        wr_ctrl(32'h3);
        rd_reg(3'd2, v0, v1); check_val("t5_clr_stat", v0, 32'h4000_0000); check_val("t5_clr_stat_ring", v1, 32'h4000_0000);
        rd_reg(3'd3, v0, v1); check_val("t5_clr_cnt", v0, 32'h0);

        // timestamp of an eop five cycles after reset release
        do_reset();
        for (int i = 0; i < 5; i++) idle();
        cap(8'h77, 1'b1);
        rd_reg(3'd5, v0, v1);
`ifdef PKTCAP_TIMESTAMP_EN
        check_val("t6_ts", v0, 32'd5);
`else
        check_val("t6_ts", v0, 32'd0);
`endif

        // randomized traffic, alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] d;
            logic v, e, r, w;
            logic [2:0] a;
            logic [31:0] wd;
            bit fill;
            fill = ((i / 400) % 2) == 0;
            d = 8'($urandom);
            v = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 5) == 0);
            r = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            w = ($urandom_range(0, 80) == 0);
            if (w && $urandom_range(0, 3) != 0) a = 3'd4;
            wd = {30'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0)};
            step(d, v, e, a, r, w, wd);
            if ($urandom_range(0, 1499) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
